saida_display: RTL and testbench

- Output-side peripheral for the processor: the processor-to-board direction of the I/O path, mirroring the switch/button input block.
- An OUT instruction strobes a binary value into the block.
- The block converts the value to decimal with a sequential shift-add-3 (double-dabble) engine and drives five active-low 7-segment digits (HEX4..HEX0).
- A one-deep pending buffer absorbs writes that arrive during a conversion; a sticky flag reports dropped writes.

---
 rtl/saida_display_if.sv | 28 ++
 rtl/saida_display.sv | 125 ++++++++++++
 tb/tb_saida_display.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/saida_display_if.sv
// Processor-to-display bus for saida_display: the write strobe plus the status and segment outputs.
interface saida_display_if #(
  parameter int DATA_W = 15
);
  // WriteEn is a one-cycle strobe with no back-pressure. The block always accepts it:
  // it starts a conversion, parks the value in the pending slot, or overwrites the slot (Dropped).
  logic              WriteEn;
  logic [DATA_W-1:0] DataIn;
  logic              Busy;
  logic              PendValid;
  logic              Dropped;
  logic [6:0]        Hex0;
  logic [6:0]        Hex1;
  logic [6:0]        Hex2;
  logic [6:0]        Hex3;
  logic [6:0]        Hex4;
  logic [1:0]        StateDbg;

  modport master (
    output WriteEn, DataIn,
    input  Busy, PendValid, Dropped, Hex0, Hex1, Hex2, Hex3, Hex4, StateDbg
  );

  modport slave (
    input  WriteEn, DataIn,
    output Busy, PendValid, Dropped, Hex0, Hex1, Hex2, Hex3, Hex4, StateDbg
  );
endinterface

// File: rtl/saida_display.sv
// Binary-to-5-digit 7-segment output block using a sequential double-dabble engine.
// Optional SAIDA_LEADING_ZERO_BLANK_EN blanks the digits above the most significant nonzero digit.
module saida_display #(
  parameter int DATA_W = 15
) (
  input logic             Clock,
  input logic             Reset,
  saida_display_if.slave  bus
);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] pend_q;
  logic              pend_valid_q;
  logic              dropped_q;
  logic [19:0]       bcd_q;
  logic [19:0]       bcd_adj;
  logic [CW-1:0]     count_q;
  logic [4:0][6:0]   hex_q;
  logic [4:0][6:0]   hex_next;
  logic [4:0]        blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    blank = '0;
`ifdef SAIDA_LEADING_ZERO_BLANK_EN
    // A digit blanks only if it and every digit above it are zero; the units digit never blanks.
    blank[4] = (bcd_q[19:16] == 4'd0);
    for (int i = 3; i >= 1; i--) begin
      blank[i] = blank[i+1] && (bcd_q[4*i +: 4] == 4'd0);
    end
`endif
    hex_next = '1;
    for (int i = 0; i < 5; i++) begin
      if (!blank[i]) hex_next[i] = seg7(bcd_q[4*i +: 4]);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      shift_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      dropped_q    <= 1'b0;
      bcd_q        <= '0;
      count_q      <= '0;
      hex_q        <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (pend_valid_q) begin
            shift_q      <= pend_q;
            pend_valid_q <= 1'b0;
            bcd_q        <= '0;
            count_q      <= '0;
            state        <= CONV;
          end else if (bus.WriteEn) begin
            shift_q <= bus.DataIn;
            bcd_q   <= '0;
            count_q <= '0;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd_q   <= {bcd_adj[18:0], shift_q[DATA_W-1]};
          shift_q <= shift_q << 1;
          count_q <= count_q + 1'b1;
          if (count_q == CW'(DATA_W - 1)) state <= LOAD;
        end
        LOAD: begin
          hex_q <= hex_next;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A write that cannot start a conversion this edge lands in the pending slot (latest wins).
      if (bus.WriteEn && (state != IDLE || pend_valid_q)) begin
        pend_q       <= bus.DataIn;
        pend_valid_q <= 1'b1;
        if (state != IDLE && pend_valid_q) dropped_q <= 1'b1;
      end
    end
  end

  assign bus.Busy      = (state != IDLE);
  assign bus.PendValid = pend_valid_q;
  assign bus.Dropped   = dropped_q;
  assign bus.Hex0      = hex_q[0];
  assign bus.Hex1      = hex_q[1];
  assign bus.Hex2      = hex_q[2];
  assign bus.Hex3      = hex_q[3];
  assign bus.Hex4      = hex_q[4];
  assign bus.StateDbg  = state;
endmodule

// File: tb/tb_saida_display.sv
// Self-checking bench for saida_display: edge-level reference model with a display queue.
module tb_saida_display;
  localparam int DW = 15;
  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};

  logic Clock;
  logic Reset;
  saida_display_if #(.DATA_W(DW)) bus ();

  saida_display #(.DATA_W(DW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;

  // reference model: conversion latency as plain arithmetic, displayed values through a queue
  int          n = 0;
  int          load_edge = 0;
  bit          m_pend_valid = 0;
  logic [DW-1:0] m_pend = '0;
  bit          m_drop = 0;
  bit          disp_valid = 0;
  logic [DW-1:0] disp_val = '0;
  logic [DW-1:0] exp_q[$];

  wire [37:0] got_vec = {bus.Busy, bus.PendValid, bus.Dropped,
                         bus.Hex4, bus.Hex3, bus.Hex2, bus.Hex1, bus.Hex0};

  function automatic logic [34:0] exp_hex(input bit valid, input int v);
    logic [34:0] r;
    int p;
    r = '1;
    p = 1;
    if (valid) begin
      for (int i = 0; i < 5; i++) begin
        int d;
        bit blk;
        d = (v / p) % 10;
        blk = 1'b0;
`ifdef SAIDA_LEADING_ZERO_BLANK_EN
        blk = (i > 0) && (v < p);
`endif
        if (!blk) r[7*i +: 7] = SEG[d];
        p = p * 10;
      end
    end
    return r;
  endfunction

  function automatic logic [37:0] exp_vec();
    return {(n < load_edge), m_pend_valid, m_drop, exp_hex(disp_valid, int'(disp_val))};
  endfunction

  task automatic model_reset();
    load_edge    = n;
    m_pend_valid = 0;
    m_drop       = 0;
    disp_valid   = 0;
    exp_q.delete();
  endtask

  // driver: one clock edge with the given write, model advanced on the same edge
  task automatic drive_edge(input bit w, input logic [DW-1:0] d);
    bus.WriteEn = w;
    bus.DataIn  = d;
    @(posedge Clock);
    n++;
    if (n == load_edge && exp_q.size() > 0) begin
      disp_val   = exp_q.pop_front();
      disp_valid = 1;
    end
    if (n > load_edge) begin
      if (m_pend_valid) begin
        exp_q.push_back(m_pend);
        load_edge    = n + DW + 1;
        m_pend_valid = w;
        if (w) m_pend = d;
      end else if (w) begin
        exp_q.push_back(d);
        load_edge = n + DW + 1;
      end
    end else if (w) begin
      if (m_pend_valid) m_drop = 1;
      m_pend       = d;
      m_pend_valid = 1;
    end
    #1;
    bus.WriteEn = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Clock);
    #1;
    total++;
    if (got_vec !== {3'b000, {35{1'b1}}}) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", got_vec, {3'b000, {35{1'b1}}});
    end
    #3 Reset = 1'b1;
  endtask

  task automatic test_known_12345();
    drive_edge(1'b1, DW'(12345));
    for (int i = 0; i < DW + 2; i++) begin
      total++;
      if (got_vec !== exp_vec()) begin
        bad++;
        $display("FAIL known_12345 edge=%0d got=%h exp=%h", n, got_vec, exp_vec());
      end
      if (i < DW) drive_edge(1'b0, '0);
      else if (i == DW) drive_edge(1'b0, '0);
    end
    total++;
    if ({bus.Hex4, bus.Hex3, bus.Hex2, bus.Hex1, bus.Hex0} !==
        {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010}) begin
      bad++;
      $display("FAIL known_12345_digits got=%h", {bus.Hex4, bus.Hex3, bus.Hex2, bus.Hex1, bus.Hex0});
    end
  endtask

  task automatic test_max_zero();
    drive_edge(1'b1, DW'(32767));
    for (int i = 0; i < DW + 2; i++) begin
      drive_edge(1'b0, '0);
      total++;
      if (got_vec !== exp_vec()) begin
        bad++;
        $display("FAIL max_value edge=%0d got=%h exp=%h", n, got_vec, exp_vec());
      end
    end
    drive_edge(1'b1, '0);
    for (int i = 0; i < DW + 2; i++) begin
      drive_edge(1'b0, '0);
      total++;
      if (got_vec !== exp_vec()) begin
        bad++;
        $display("FAIL zero_value edge=%0d got=%h exp=%h", n, got_vec, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    drive_edge(1'b1, DW'(100));
    drive_edge(1'b1, DW'(42));
    total++;
    if (bus.PendValid !== 1'b1) begin
      bad++;
      $display("FAIL pend_immediate got=%b exp=1", bus.PendValid);
    end
    for (int i = 0; i < 2 * DW + 6; i++) begin
      drive_edge(1'b0, '0);
      total++;
      if (got_vec !== exp_vec()) begin
        bad++;
        $display("FAIL back_to_back edge=%0d got=%h exp=%h", n, got_vec, exp_vec());
      end
    end
  endtask

  task automatic test_drop();
    drive_edge(1'b1, DW'(7));
    drive_edge(1'b1, DW'(8));
    drive_edge(1'b1, DW'(9));
    for (int i = 0; i < 2 * DW + 8; i++) begin
      total++;
      if (got_vec !== exp_vec()) begin
        bad++;
        $display("FAIL drop edge=%0d got=%h exp=%h", n, got_vec, exp_vec());
      end
      drive_edge(1'b0, '0);
    end
  endtask

  task automatic test_reset_mid();
    drive_edge(1'b1, DW'(1234));
    drive_edge(1'b1, DW'(99));
    repeat (4) drive_edge(1'b0, '0);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    total++;
    if (got_vec !== exp_vec()) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", got_vec, exp_vec());
    end
    @(posedge Clock);
    #3 Reset = 1'b1;
    drive_edge(1'b1, DW'(5));
    for (int i = 0; i < DW + 3; i++) begin
      total++;
      if (got_vec !== exp_vec()) begin
        bad++;
        $display("FAIL after_reset edge=%0d got=%h exp=%h", n, got_vec, exp_vec());
      end
      drive_edge(1'b0, '0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit w;
      w = ($urandom_range(0, 7) == 0);
      drive_edge(w, DW'($urandom_range(0, 32767)));
      total++;
      if (got_vec !== exp_vec()) begin
        bad++;
        $display("FAIL random edge=%0d got=%h exp=%h", n, got_vec, exp_vec());
      end
    end
  endtask

  initial begin
    Reset       = 1'b0;
    bus.WriteEn = 1'b0;
    bus.DataIn  = '0;
    test_reset();
    test_known_12345();
    test_max_zero();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
